// File: rtl/pipe_stage_buf_if.sv
// Handshake bundle for pipe_stage_buf: upstream valid/ready/data plus downstream valid/ready/data.
// master drives the stage inputs (producer + consumer side); slave is the stage itself.
interface pipe_stage_buf_if #(
  parameter int DATA_W = 32
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/pipe_stage_buf.sv
// Elastic pipeline stage: main reg M plus skid reg S; all outputs are registered, latency 1 cycle.
// in_ready = ~S valid so out_ready never reaches in_ready combinationally; PIPE_STAGE_STALL_CNT_EN adds stall_cnt.
module pipe_stage_buf #(
  parameter int                DATA_W   = 32,
  parameter logic [DATA_W-1:0] NOP_DATA = {DATA_W{1'b0}},
  parameter int                CNT_W    = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic                flush,
  pipe_stage_buf_if.slave     bus,
`ifdef PIPE_STAGE_STALL_CNT_EN
  output logic [CNT_W-1:0]    stall_cnt,
`endif
  output logic [1:0]          occupancy
);

  logic              m_valid_q, m_valid_d;
  logic              s_valid_q, s_valid_d;
  logic [DATA_W-1:0] m_data_q,  m_data_d;
  logic [DATA_W-1:0] s_data_q,  s_data_d;
  logic              in_fire;
  logic              out_fire;

  assign in_fire  = en & bus.in_valid & ~s_valid_q;
  assign out_fire = en & m_valid_q & bus.out_ready;

  always_comb begin
    m_valid_d = m_valid_q;
    s_valid_d = s_valid_q;
    m_data_d  = m_data_q;
    s_data_d  = s_data_q;
    if (flush) begin
      m_valid_d = 1'b0;
      s_valid_d = 1'b0;
      m_data_d  = NOP_DATA;
      s_data_d  = NOP_DATA;
    end else if (!m_valid_q) begin
      if (in_fire) begin
        m_valid_d = 1'b1;
        m_data_d  = bus.in_data;
      end
    end else if (!s_valid_q) begin
      if (in_fire && out_fire) begin
        m_data_d = bus.in_data;
      end else if (in_fire) begin
        // Downstream stalled: park the new item in the skid slot.
        s_valid_d = 1'b1;
        s_data_d  = bus.in_data;
      end else if (out_fire) begin
        m_valid_d = 1'b0;
        m_data_d  = NOP_DATA;
      end
    end else if (out_fire) begin
      m_data_d  = s_data_q;
      s_valid_d = 1'b0;
      s_data_d  = NOP_DATA;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      m_valid_q <= 1'b0;
      s_valid_q <= 1'b0;
      m_data_q  <= NOP_DATA;
      s_data_q  <= NOP_DATA;
    end else begin
      m_valid_q <= m_valid_d;
      s_valid_q <= s_valid_d;
      m_data_q  <= m_data_d;
      s_data_q  <= s_data_d;
    end
  end

  assign bus.in_ready  = ~s_valid_q;
  assign bus.out_valid = m_valid_q;
  assign bus.out_data  = m_data_q;
  assign occupancy     = {1'b0, m_valid_q} + {1'b0, s_valid_q};

`ifdef PIPE_STAGE_STALL_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  // Flush does not clear the counter; only reset does.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (en && m_valid_q && !bus.out_ready && !(&stall_cnt_q)) begin
      stall_cnt_d = stall_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: doc/pipe_stage_buf.md
Name: pipe_stage_buf

Overview:
Parametrised elastic pipeline stage register, the successor to the fixed IF/ID, ID/EX, EX/MEM and MEM/WB latches. It replaces global stall wiring with a per-stage valid/ready handshake and a 2-entry skid buffer, so upstream ready is registered and no stall path crosses the stage combinationally. It also supports a synchronous flush for branch mispredicts and a global enable that mirrors the chip-level rdy.

Parameters:
DATA_W, 32, width of the payload bundle carried through the stage.
NOP_DATA, {DATA_W{1'b0}}, value driven on out_data whenever out_valid=0 (after reset, flush or drain).
CNT_W, 16, width of stall_cnt; used only when PIPE_STAGE_STALL_CNT_EN is defined.

Ports:
clk  in  1  clock; all state updates on posedge.
rst  in  1  synchronous reset, active-low.
en  in  1  global enable (chip rdy); 0 freezes all state except flush.
flush  in  1  synchronous kill of all held entries.
in_valid  in  1  upstream payload valid.
in_ready  out  1  stage can accept; registered.
in_data  in  DATA_W  upstream payload.
out_valid  out  1  payload valid to downstream.
out_ready  in  1  downstream accepts.
out_data  out  DATA_W  payload to downstream; registered.
occupancy  out  2  entries held: 0, 1 or 2.

Behaviour:
- Storage: main register M (drives out_data/out_valid) and skid register S. Outputs come straight from flops; no combinational path in_* -> out_* or out_ready -> in_ready.
- in_fire = en & in_valid & in_ready. out_fire = en & out_valid & out_ready.
- in_ready = ~S_valid. occupancy = M_valid + S_valid.
- States: EMPTY (M,S invalid), HALF (M valid), FULL (M,S valid). S_valid implies M_valid.
- EMPTY: in_fire -> M<=in_data, HALF; otherwise stay.
- HALF, in_fire & out_fire -> M<=in_data, stay HALF (1 item/cycle throughput).
- HALF, in_fire & ~out_fire -> S<=in_data, FULL.
- HALF, ~in_fire & out_fire -> M<=NOP_DATA, EMPTY.
- HALF, neither -> hold.
- FULL: in_ready=0, so no in_fire. out_fire -> M<=S, S<=NOP_DATA, HALF; otherwise hold.
- Latency in->out: 1 cycle when EMPTY, or HALF with out_fire. Ordering is strictly FIFO.
- Stability: while out_valid & ~out_ready, out_data is unchanged.
- en=0: no transfers and all state held, even if in_valid/out_ready are asserted.
- flush=1 (any en): next state EMPTY, M=S=NOP_DATA, in_ready=1. An in_fire or out_fire in the same cycle is discarded.
- Priority: rst > flush > en/handshake.
- Reset (rst=0 at posedge, including mid-transfer): EMPTY, out_valid=0, out_data=NOP_DATA, in_ready=1, occupancy=0, stall_cnt=0. Held data is dropped.
- Upstream may drop in_valid at any time; the stage places no protocol requirement on it.

Optional Feature:
PIPE_STAGE_STALL_CNT_EN: adds output port stall_cnt [CNT_W-1:0].
- Increments each cycle with en & out_valid & ~out_ready.
- Saturates at all-ones.
- Cleared by reset only; flush and en=0 do not clear it, and it does not count while en=0.
- Without the macro, the port and counter logic are absent; behaviour is otherwise identical.

Test Plan:
- Streaming: reset, then in_valid=1 with in_data=1,2,3,4 on consecutive cycles, out_ready=1 -> out_data 1,2,3,4 one cycle later each; in_ready stays 1; occupancy stays 1.
- Backpressure/skid: send 0xA, 0xB with out_ready=0 -> after 2 cycles occupancy=2, in_ready=0, out_data=0xA held. Raise out_ready -> 0xA, then 0xB, then out_valid=0 with out_data=NOP_DATA.
- Flush: FULL with 0xA/0xB, then flush=1 together with in_valid=1 carrying 0xC -> next cycle out_valid=0, occupancy=0, in_ready=1, out_data=NOP_DATA; 0xC is never output.
- Enable freeze: HALF holding 0x5, en=0 for 3 cycles with in_valid=1 and out_ready=1 -> state, out_data=0x5 and occupancy=1 unchanged. en=1 -> 0x5 consumed on the next edge.
- Reset mid-operation: FULL, then rst=0 for one cycle -> out_valid=0, in_ready=1, occupancy=0, and stall_cnt=0 when the macro is defined.
- Stall counter (macro defined, CNT_W=2): hold out_valid=1, out_ready=0 for 5 cycles -> stall_cnt 1,2,3,3,3; a flush leaves it at 3.
